// File: rtl/countdown_arena_if.sv
// Control and status bundle for countdown_arena.
// master drives start/from/stop; slave reports count and results.
interface countdown_arena_if #(
  parameter int WIDTH   = 7,
  parameter int PLAYERS = 2
);
  logic               start;
  logic [WIDTH-1:0]   from;
  logic [PLAYERS-1:0] stop;
  logic [WIDTH-1:0]   current;
  logic [PLAYERS-1:0] win;
  logic [PLAYERS-1:0] lose;
  logic               step;
  logic               running;
  logic               done;

  modport master (
    output start,
    output from,
    output stop,
    input  current,
    input  win,
    input  lose,
    input  step,
    input  running,
    input  done
  );

  modport slave (
    input  start,
    input  from,
    input  stop,
    output current,
    output win,
    output lose,
    output step,
    output running,
    output done
  );
endinterface

// File: rtl/countdown_arena.sv
// Multi-player countdown game: prescaled down-counter,
// independent per-player stop judging, timeout loss.
module countdown_arena #(
  parameter int CLOCK_DIV = 50000000,
  parameter int DIV_W     = 26,
  parameter int WIDTH     = 7,
  parameter int PLAYERS   = 2
) (
  input logic              clk,
  input logic              reset,
  countdown_arena_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [DIV_W-1:0] LAST =
    DIV_W'(CLOCK_DIV - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cur_q, cur_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PLAYERS-1:0] win_q, win_d;
  logic [PLAYERS-1:0] lose_q, lose_d;
  logic [PLAYERS-1:0] stp_q, stp_d;
  logic               step_q, step_d;
  logic [PLAYERS-1:0] hit;
  logic               zero;
  logic               tick;

  assign hit  = bus.stop & ~stp_q;
  assign zero = (cur_q == '0);
  assign tick = (div_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      div_q   <= '0;
      win_q   <= '0;
      lose_q  <= '0;
      stp_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      div_q   <= div_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      stp_q   <= stp_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    div_d   = div_q;
    win_d   = win_q;
    lose_d  = lose_q;
    stp_d   = stp_q;
    step_d  = 1'b0;
    unique case (1'b1)
      bus.start: begin
        state_d = RUN;
        cur_d   = bus.from;
        div_d   = '0;
        win_d   = '0;
        lose_d  = '0;
        stp_d   = '0;
      end
      !bus.start && state_q == RUN: begin
        // stops are judged on the pre-step count
        stp_d = stp_q | hit;
        if (zero) win_d = win_q | hit;
        else      lose_d = lose_q | hit;
        if (&stp_d) begin
          state_d = DONE;
        end else if (tick) begin
          step_d = 1'b1;
          div_d  = '0;
          if (zero) begin
            lose_d  = lose_d | ~stp_d;
            state_d = DONE;
          end else begin
            cur_d = cur_q - WIDTH'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.current = cur_q;
  assign bus.win     = win_q;
  assign bus.lose    = lose_q;
  assign bus.step    = step_q;
  assign bus.running = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_countdown_arena.sv
// Bench for countdown_arena: two instances (prescale 4 and 1)
// share stimulus; a monitor scores each finished game.
module tb_countdown_arena;
  localparam int W = 7;
  localparam int P = 2;

  typedef struct {
    logic [P-1:0] win;
    logic [P-1:0] lose;
    logic [W-1:0] cur;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] from = '0;
  logic [P-1:0] stop = '0;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  exp_t         sb[2][$];

  countdown_arena_if #(.WIDTH(W), .PLAYERS(P)) i4 ();
  countdown_arena_if #(.WIDTH(W), .PLAYERS(P)) i1 ();

  assign i4.start = start;
  assign i4.from  = from;
  assign i4.stop  = stop;
  assign i1.start = start;
  assign i1.from  = from;
  assign i1.stop  = stop;

  countdown_arena #(
    .CLOCK_DIV(4), .DIV_W(2), .WIDTH(W), .PLAYERS(P)
  ) u4 (
    .clk(clk), .reset(reset), .bus(i4)
  );

  countdown_arena #(
    .CLOCK_DIV(1), .DIV_W(1), .WIDTH(W), .PLAYERS(P)
  ) u1 (
    .clk(clk), .reset(reset), .bus(i1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] cur[2];
  logic [P-1:0] w[2];
  logic [P-1:0] l[2];
  logic         dn[2];
  logic         rn[2];
  logic         st[2];

  assign cur[0] = i4.current;
  assign cur[1] = i1.current;
  assign w[0]   = i4.win;
  assign w[1]   = i1.win;
  assign l[0]   = i4.lose;
  assign l[1]   = i1.lose;
  assign dn[0]  = i4.done;
  assign dn[1]  = i1.done;
  assign rn[0]  = i4.running;
  assign rn[1]  = i1.running;
  assign st[0]  = i4.step;
  assign st[1]  = i1.step;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Outcome of one game from the rules: stop edges t0/t1 counted
  // from the start edge (0 = never pressed).
  function automatic exp_t model(
    int d, int f, int t0, int t1, int base
  );
    exp_t r;
    int   ts[2];
    int   tt;
    int   e;
    bit   all;
    ts[0] = t0;
    ts[1] = t1;
    tt    = (f + 1) * d;
    e     = 0;
    all   = 1'b1;
    r.win  = '0;
    r.lose = '0;
    for (int i = 0; i < 2; i++) begin
      if (ts[i] >= 1 && ts[i] <= tt) begin
        if (ts[i] > f * d) r.win[i] = 1'b1;
        else               r.lose[i] = 1'b1;
        if (ts[i] > e) e = ts[i];
      end else begin
        all       = 1'b0;
        r.lose[i] = 1'b1;
      end
    end
    if (!all) e = tt;
    r.cur = W'(f - (e - 1) / d);
    r.cyc = base + e;
    return r;
  endfunction

  logic prev[2] = '{1'b0, 1'b0};
  exp_t held[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        prev[k] = 1'b0;
      end else begin
        chk($sformatf("d%0d_exclusive", k),
            32'(w[k] & l[k]), 0);
        if (dn[k] && !prev[k]) begin
          if (sb[k].size() == 0) begin
            chk($sformatf("d%0d_spurious_done", k), 1, 0);
          end else begin
            held[k] = sb[k].pop_front();
            chk($sformatf("d%0d_win", k),
                32'(w[k]), 32'(held[k].win));
            chk($sformatf("d%0d_lose", k),
                32'(l[k]), 32'(held[k].lose));
            chk($sformatf("d%0d_current", k),
                32'(cur[k]), 32'(held[k].cur));
            chk($sformatf("d%0d_done_cycle", k),
                cyc, held[k].cyc);
          end
        end else if (dn[k]) begin
          chk($sformatf("d%0d_hold_win", k),
              32'(w[k]), 32'(held[k].win));
          chk($sformatf("d%0d_hold_lose", k),
              32'(l[k]), 32'(held[k].lose));
          chk($sformatf("d%0d_hold_cur", k),
              32'(cur[k]), 32'(held[k].cur));
          chk($sformatf("d%0d_hold_running", k),
              32'(rn[k]), 0);
        end
        prev[k] = dn[k];
      end
    end
  end

  task automatic game(int f, int t0, int t1);
    exp_t e4;
    exp_t e1;
    int   base;
    int   em;
    @(negedge clk);
    base = cyc + 1;
    e4 = model(4, f, t0, t1, base);
    e1 = model(1, f, t0, t1, base);
    sb[0].push_back(e4);
    sb[1].push_back(e1);
    em = (e4.cyc > e1.cyc ? e4.cyc : e1.cyc) - base;
    start = 1'b1;
    from  = W'(f);
    stop  = '0;
    for (int t = 1; t <= em + 2; t++) begin
      @(negedge clk);
      start   = 1'b0;
      stop[0] = (t0 != 0 && t >= t0);
      stop[1] = (t1 != 0 && t >= t1);
    end
  endtask

  initial begin
    int base;
    int f;
    int ta;
    int tb;

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cur", 32'(i4.current), 0);
    chk("rst_win", 32'(i4.win), 0);
    chk("rst_lose", 32'(i4.lose), 0);
    chk("rst_step", 32'(i4.step), 0);
    chk("rst_running", 32'(i4.running), 0);
    chk("rst_done", 32'(i4.done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cur", 32'(i4.current), 0);
    chk("idle_running", 32'(i4.running), 0);

    // restart mid-run: count 6 reloaded with 5
    start = 1'b1;
    from  = 7'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_restart_cur", 32'(i4.current), 6);
    base = cyc + 1;
    sb[0].push_back(model(4, 5, 0, 0, base));
    sb[1].push_back(model(1, 5, 0, 0, base));
    start = 1'b1;
    from  = 7'd5;
    @(negedge clk);
    start = 1'b0;
    chk("restart_cur", 32'(i4.current), 5);
    chk("restart_win", 32'(i4.win), 0);
    chk("restart_lose", 32'(i4.lose), 0);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chk($sformatf("restart_step_%0d", t),
          32'(i4.step), (t == 4) ? 1 : 0);
    end
    chk("restart_cur_after_step", 32'(i4.current), 4);
    repeat (22) @(negedge clk);

    game(3, 13, 0);
    game(2, 9, 2);
    game(1, 5, 5);
    game(1, 8, 0);

    // asynchronous reset between edges
    @(negedge clk);
    start = 1'b1;
    from  = 7'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_cur", 32'(i4.current), 0);
    chk("async_win", 32'(i4.win), 0);
    chk("async_lose", 32'(i4.lose), 0);
    chk("async_running", 32'(i4.running), 0);
    chk("async_running_d1", 32'(i1.running), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_step", 32'(i4.step), 0);
    chk("post_rst_cur", 32'(i4.current), 0);

    game(0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      f  = int'($urandom_range(0, 5));
      ta = ($urandom_range(0, 3) == 0) ? 0 :
           int'($urandom_range(1, (f + 1) * 4 + 2));
      tb = ($urandom_range(0, 3) == 0) ? 0 :
           int'($urandom_range(1, (f + 1) * 4 + 2));
      game(f, ta, tb);
    end

    @(negedge clk);
    chk("drain_d4", sb[0].size(), 0);
    chk("drain_d1", sb[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
